// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction loader and the core it feeds.
package proc_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/idle_timer.sv
// Counts idle cycles between accepted bytes and flags when TIMEOUT is reached.
// TIMEOUT = 0 disables the flag entirely.
module idle_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Saturates at LIMIT so the flag stays up until the FSM leaves the timed states.
    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/instr_loader.sv
// Fills instruction memory from a length-prefixed byte stream and holds the core
// in reset until a load completes. Define LOADER_CHECKSUM_EN for the XOR check byte.
module instr_loader #(
    parameter int ADDR_W  = proc_pkg::ADDR_W,
    parameter int INSTR_W = proc_pkg::INSTR_W,
    parameter int TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_rst,
    output logic               load_done,
    output logic               load_err,
    output logic [ADDR_W:0]    words_loaded
);

    import proc_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    state_t            state, next_state;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        hi_byte;
    logic              byte_accepted;
    logic              timed_state;
    logic              expired;
    logic              start_load;
    state_t            after_last;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;
    assign after_last = CHK;
`else
    assign after_last = DONE;
`endif

    assign byte_accepted = in_valid && in_ready;
    assign timed_state   = (state == HI) || (state == LO) || (state == CHK);
    assign start_load    = load_req && ((state == IDLE) || (state == DONE) || (state == ERR));

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (timed_state),
        .clear   (byte_accepted),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An expired timer wins over a byte arriving in the same cycle, so in_ready drops with it.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (load_req) next_state = LEN;
            end
            LEN: begin
                in_ready = 1'b1;
                if (in_valid) next_state = HI;
            end
            HI: begin
                if (expired) begin
                    next_state = ERR;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) next_state = LO;
                end
            end
            LO: begin
                if (expired) begin
                    next_state = ERR;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) next_state = (remaining == CNT_W'(1)) ? after_last : HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (expired) begin
                    next_state = ERR;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) next_state = (in_data == xor_acc) ? DONE : ERR;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // cpu_rst only drops after a full cycle in DONE, so the final write lands first.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining    <= '0;
            addr         <= '0;
            hi_byte      <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we  <= 1'b0;
            cpu_rst <= !((state == DONE) && (next_state == DONE));
            if (start_load) begin
                load_done    <= 1'b0;
                load_err     <= 1'b0;
                words_loaded <= '0;
            end
            if ((next_state == DONE) && (state != DONE)) load_done <= 1'b1;
            if ((next_state == ERR) && (state != ERR)) load_err <= 1'b1;
            if (byte_accepted) begin
                case (state)
                    LEN: begin
                        remaining <= (in_data == 8'd0) ? CNT_W'(256) : CNT_W'(in_data);
                        addr      <= '0;
                    end
                    HI: hi_byte <= in_data;
                    LO: begin
                        mem_we       <= 1'b1;
                        mem_addr     <= addr;
                        mem_wdata    <= {hi_byte, in_data};
                        addr         <= addr + ADDR_W'(1);
                        remaining    <= remaining - CNT_W'(1);
                        words_loaded <= words_loaded + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_acc <= '0;
        end else if (byte_accepted) begin
            if (state == LEN) xor_acc <= '0;
            else if ((state == HI) || (state == LO)) xor_acc <= xor_acc ^ in_data;
        end
    end
`endif

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream stage that fills the processor's instruction memory before execution.
- Accepts a byte stream through a valid/ready handshake and assembles the bytes into 16-bit instructions.
- Writes each instruction into instruction memory at sequential addresses from 0.
- Holds the core in reset (cpu_rst) until a load completes cleanly; on completion, releases the core so its PC starts at 0.

Parameters:
- ADDR_W, 8: instruction memory address width. Matches the 8-bit PC.
- INSTR_W, 16: instruction width. Fixed at two bytes; any other value is unsupported.
- TIMEOUT, 1000000: maximum idle cycles between bytes during a load. 0 disables the timeout.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- load_req, input, 1: single-cycle request to start a load.
- in_data, input, 8: incoming stream byte.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: loader can accept a byte.
- mem_we, output, 1: instruction memory write strobe.
- mem_addr, output, ADDR_W: instruction memory write address.
- mem_wdata, output, INSTR_W: instruction memory write data.
- cpu_rst, output, 1: reset to the PC and the rest of the core.
- load_done, output, 1: last load completed successfully.
- load_err, output, 1: last load aborted.
- words_loaded, output, ADDR_W+1: number of instructions written in the current or last load.

Behaviour:
- Reset values: cpu_rst=1, all other outputs 0, state IDLE.
- A byte is accepted on a cycle where in_valid && in_ready.
- in_ready=1 only in states LEN, HI, LO and CHK.
- Stream format:
  - First byte is the length N. N=0 means 256 instructions.
  - Then 2N bytes, high byte first.
- State transitions:
  - IDLE: load_req -> LEN. Also clears load_done, load_err and words_loaded.
  - LEN: accept byte -> latch remaining count (9-bit), set address to 0 -> HI.
  - HI: accept byte -> latch the high byte -> LO.
  - LO: accept byte -> register the write (see write timing below).
    - If remaining count was 1 -> CHK if the macro is defined, else DONE.
    - Otherwise -> HI.
  - DONE: load_done=1, cpu_rst=0. load_req -> LEN, with cpu_rst=1 from the next cycle.
  - ERR: load_err=1, cpu_rst=1. load_req -> LEN.
- Write timing:
  - mem_we pulses for exactly one cycle, the cycle after the LO byte is accepted.
  - mem_addr and mem_wdata are registered and valid in that same cycle.
  - The address increments after each write.
  - The maximum address is 255; no wrap occurs because N is at most 256.
- cpu_rst is 1 in every state except DONE. It deasserts the cycle after the final write; no write is pending while the core runs.
- Timeout:
  - Applies in HI, LO and CHK only, not LEN.
  - The counter is cleared on every accepted byte.
  - When the counter reaches TIMEOUT -> ERR.
- load_req is ignored in LEN, HI, LO and CHK.
- in_valid is ignored while in_ready=0.
- rst at any point returns the block to reset values. A registered write not yet issued is dropped.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last LO byte, state CHK accepts one byte.
  - The byte must equal the XOR of all 2N data bytes. Match -> DONE; mismatch -> ERR.
  - Memory writes already performed are not undone.
- Undefined: CHK state and the XOR register do not exist; the last LO byte leads to DONE.

Decomposition:
- Shared package `proc_pkg`:
  - state enum: IDLE, LEN, HI, LO, CHK, DONE, ERR.
  - INSTR_W = 16 and ADDR_W = 8 constants.
- One sub-module, `idle_timer`: loadable counter with clear-on-byte and an expired flag, parameterised by TIMEOUT.

Test Plan:
- Basic load: load_req, then 03 12 34 56 78 9A BC.
  - Required: writes addr0=1234, addr1=5678, addr2=9ABC, one mem_we pulse each.
  - words_loaded=3, load_done=1, cpu_rst falls the cycle after the third write.
- Full-size load: length byte 00 followed by 512 bytes.
  - Required: 256 writes, last at addr FF; words_loaded=256; no address wrap.
- Timeout: TIMEOUT=16, in_valid gaps of 15 cycles, then a 16-cycle gap after the HI byte.
  - Required: load completes with 15-cycle gaps; the 16-cycle gap gives ERR, load_err=1, cpu_rst stays 1, no further mem_we.
- Reset mid-load: rst asserted in the cycle the LO byte is accepted.
  - Required: no mem_we; next cycle is IDLE with cpu_rst=1 and all flags 0.
- Reload: load_req while in DONE, then 01 AB CD.
  - Required: cpu_rst=1 the next cycle; addr0 is overwritten with ABCD; load_done returns to 1.
- Checksum (LOADER_CHECKSUM_EN): 01 12 34 26 -> DONE; 01 12 34 27 -> ERR.
  - In both cases addr0=1234 was written.
